// File: rtl/hamming_decoder_pkg.sv
// Shared definitions for the (16,11) SECDED byte-stream decoder.
// FSM states, status codes, codeword layout constants.
package hamming_decoder_pkg;

  typedef enum logic [2:0] {
    IN0,
    IN1,
    DEC,
    OUT0,
    OUT1
  } dec_state_t;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_CORR = 2'b01,
    ST_DBL  = 2'b10
  } dec_status_t;

  localparam int unsigned POS_P0 = 0;
  localparam int unsigned POS_H1 = 1;
  localparam int unsigned POS_H2 = 2;
  localparam int unsigned POS_H4 = 4;
  localparam int unsigned POS_H8 = 8;

  function automatic logic [10:0] extract_data(input logic [15:0] w);
    return {w[15:9], w[7:5], w[3]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational SECDED check of one 16-bit codeword.
// Produces syndrome, overall parity, corrected data and status.
module hamming_syndrome
  import hamming_decoder_pkg::*;
(
  input  logic [15:0] w,
  output logic [3:0]  s,
  output logic        p,
  output logic [10:0] d,
  output logic [1:0]  status
);

  logic [15:0] wc;
  dec_status_t st;

  always_comb begin
    s = '0;
    for (int i = 1; i < 16; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (i[k]) s[k] = s[k] ^ w[i];
      end
    end
    p  = ^w;
    wc = w;
    st = ST_OK;
    if (s == 4'd0) begin
      if (p) st = ST_CORR;
    end else if (p) begin
      // w0 is never addressed here: s==0 means the error sits in w0
      wc[s] = ~wc[s];
      st    = ST_CORR;
    end else begin
      st = ST_DBL;
    end
    d      = extract_data(wc);
    status = st;
  end

endmodule

// File: rtl/hamming_decoder.sv
// Byte-stream SECDED decoder with valid/ready on both sides.
// Optional saturating stats counters: define HAMMING_DEC_STATS_EN.
module hamming_decoder
  import hamming_decoder_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [7:0]       OUT_DATA,
  output logic [1:0]       STATUS
`ifdef HAMMING_DEC_STATS_EN
  ,
  output logic [CNT_W-1:0] CORR_CNT,
  output logic [CNT_W-1:0] DBL_CNT
`endif
);

  dec_state_t  state_q, state_d;
  logic [15:0] w_q, w_d;
  logic [10:0] d_q, d_d;
  logic [1:0]  status_q, status_d;

  logic [10:0] syn_d;
  logic [1:0]  syn_status;
  logic        in_fire;
  logic        out_fire;

  hamming_syndrome u_syn (
    .w      (w_q),
    .s      (),
    .p      (),
    .d      (syn_d),
    .status (syn_status)
  );

  assign IN_READY  = (state_q == IN0) || (state_q == IN1);
  assign OUT_VALID = (state_q == OUT0) || (state_q == OUT1);
  assign in_fire   = IN_VALID && IN_READY;
  assign out_fire  = OUT_VALID && OUT_READY;
  assign STATUS    = status_q;

  always_comb begin
    unique case (state_q)
      OUT0:    OUT_DATA = d_q[7:0];
      OUT1:    OUT_DATA = {status_q, 3'b000, d_q[10:8]};
      default: OUT_DATA = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    d_d      = d_q;
    status_d = status_q;
    unique case (state_q)
      IN0: if (in_fire) begin
        if (MSB_FIRST) w_d[15:8] = IN_DATA;
        else           w_d[7:0]  = IN_DATA;
        state_d = IN1;
      end
      IN1: if (in_fire) begin
        if (MSB_FIRST) w_d[7:0]  = IN_DATA;
        else           w_d[15:8] = IN_DATA;
        state_d = DEC;
      end
      DEC: begin
        d_d      = syn_d;
        status_d = syn_status;
        state_d  = OUT0;
      end
      OUT0:    if (out_fire) state_d = OUT1;
      OUT1:    if (out_fire) state_d = IN0;
      default: state_d = IN0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IN0;
      w_q      <= '0;
      d_q      <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      d_q      <= d_d;
      status_q <= status_d;
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] dbl_q, dbl_d;

  always_comb begin
    corr_d = corr_q;
    dbl_d  = dbl_q;
    if (state_q == DEC) begin
      if (syn_status == ST_CORR && !(&corr_q)) corr_d = corr_q + 1'b1;
      if (syn_status == ST_DBL && !(&dbl_q))   dbl_d  = dbl_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      corr_q <= '0;
      dbl_q  <= '0;
    end else begin
      corr_q <= corr_d;
      dbl_q  <= dbl_d;
    end
  end

  assign CORR_CNT = corr_q;
  assign DBL_CNT  = dbl_q;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder (MSB_FIRST=0).
// Checks stats ports when HAMMING_DEC_STATS_EN is defined.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] status;
`ifdef HAMMING_DEC_STATS_EN
  logic [15:0] corr_cnt;
  logic [15:0] dbl_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hamming_decoder dut (
    .CLK       (clk),
    .RESET     (reset),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .STATUS    (status)
`ifdef HAMMING_DEC_STATS_EN
    ,
    .CORR_CNT  (corr_cnt),
    .DBL_CNT   (dbl_cnt)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_timeout", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    check(tag, {8'd0, out_data}, {8'd0, exp});
    tick();
    out_ready = 1'b0;
  endtask

  task automatic word(input string tag, input logic [7:0] lo,
                      input logic [7:0] hi, input logic [7:0] e0,
                      input logic [7:0] e1, input logic [1:0] est);
    send_byte(lo);
    send_byte(hi);
    recv_byte({tag, "_b0"}, e0);
    recv_byte({tag, "_b1"}, e1);
    check({tag, "_status"}, {14'd0, status}, {14'd0, est});
  endtask

  initial begin
    logic stable;
    int   n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_data", {8'd0, out_data}, 16'd0);
    check("rst_status", {14'd0, status}, 16'd0);

    // Test 1 with latency: DEC cycle, then OUT0 visible at edge t+2
    send_byte(8'hFF);
    send_byte(8'hFF);
    check("lat_dec_valid", {15'd0, out_valid}, 16'd0);
    check("lat_dec_in_ready", {15'd0, in_ready}, 16'd0);
    tick();
    check("lat_out_valid", {15'd0, out_valid}, 16'd1);
    recv_byte("t1_b0", 8'hFF);
    recv_byte("t1_b1", 8'h07);
    check("t1_status", {14'd0, status}, 16'd0);

    word("t2", 8'hFE, 8'hFF, 8'hFF, 8'h47, 2'b01);
    word("t3", 8'h08, 8'h00, 8'h00, 8'h40, 2'b01);
    word("t4", 8'h03, 8'h00, 8'h00, 8'h80, 2'b10);
    word("t_w15", 8'hFF, 8'h7F, 8'hFF, 8'h47, 2'b01);
`ifdef HAMMING_DEC_STATS_EN
    check("corr_cnt", corr_cnt, 16'd3);
    check("dbl_cnt", dbl_cnt, 16'd1);
`endif

    // Test 5: stall in OUT0
    send_byte(8'hFF);
    send_byte(8'hFF);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("t5_valid", {15'd0, out_valid}, 16'd1);
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (out_data !== 8'hFF || in_ready !== 1'b0 || out_valid !== 1'b1)
        stable = 1'b0;
    end
    check("t5_stall_stable", {15'd0, stable}, 16'd1);
    recv_byte("t5_b0", 8'hFF);
    recv_byte("t5_b1", 8'h07);

    // Test 6: reset after first byte discards it
    send_byte(8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_in_ready", {15'd0, in_ready}, 16'd1);
    check("t6_out_valid", {15'd0, out_valid}, 16'd0);
    check("t6_status", {14'd0, status}, 16'd0);
`ifdef HAMMING_DEC_STATS_EN
    check("t6_corr_clr", corr_cnt, 16'd0);
    check("t6_dbl_clr", dbl_cnt, 16'd0);
`endif
    word("t6", 8'hFF, 8'hFF, 8'hFF, 8'h07, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
